// File: rtl/maze_pixel_src_pkg.sv
// Shared types and constants for the maze pixel source: palette, map geometry,
// move directions and the game state.
package maze_pkg;

  localparam logic [11:0] WALL   = 12'h333;
  localparam logic [11:0] FLOOR  = 12'hFFF;
  localparam logic [11:0] PLAYER = 12'hF00;
  localparam logic [11:0] EXIT   = 12'h0F0;
  localparam logic [11:0] BLANK  = 12'h000;

  localparam int TILE_BITS = 5;
  localparam int MAP_W     = 20;
  localparam int MAP_H     = 15;

  // Player marker occupies this inclusive pixel range inside its tile, on both axes
  localparam logic [TILE_BITS-1:0] MARK_LO = 5'd4;
  localparam logic [TILE_BITS-1:0] MARK_HI = 5'd27;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

  typedef enum logic {PLAY, WIN} state_e;

  function automatic logic is_single(input logic [3:0] req);
    return (req != 4'd0) && ((req & (req - 4'd1)) == 4'd0);
  endfunction

  function automatic dir_e req_to_dir(input logic [3:0] req);
    dir_e dir;
    dir = DIR_UP;
    if (req[1]) dir = DIR_DOWN;
    if (req[2]) dir = DIR_LEFT;
    if (req[3]) dir = DIR_RIGHT;
    return dir;
  endfunction

endpackage

// File: rtl/maze_pixel_src_if.sv
// Pixel bus between the VGA controller (master) and the maze pixel source (slave).
interface maze_pixel_src_if;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic        vs;
  logic [11:0] d_out;

  modport master (output row_addr, col_addr, rdn, vs, input d_out);
  modport slave  (input row_addr, col_addr, rdn, vs, output d_out);
endinterface

// File: rtl/maze_map_rom.sv
// Combinational maze layout: border walls, one vertical and one horizontal inner wall.
module maze_map_rom
  import maze_pkg::*;
(
  input  logic [4:0] tx,
  input  logic [3:0] ty,
  output logic       wall
);

  // Anything at or beyond the last column/row is treated as wall, covering out-of-range tiles
  always_comb begin
    wall = 1'b0;
    if (tx == 5'd0 || ty == 4'd0 || tx >= 5'(MAP_W - 1) || ty >= 4'(MAP_H - 1)) begin
      wall = 1'b1;
    end else if (tx == 5'd10 && ty <= 4'd11) begin
      wall = 1'b1;
    end else if (ty == 4'd7 && tx >= 5'd3 && tx <= 5'd8) begin
      wall = 1'b1;
    end
  end

endmodule

// File: rtl/maze_pixel_src.sv
// Maze game pixel source: renders the map, player and exit for vgac, and moves the
// player at most once per frame, only at frame start.
module maze_pixel_src
  import maze_pkg::*;
#(
  parameter int unsigned START_X = 1,
  parameter int unsigned START_Y = 1,
  parameter int unsigned EXIT_X  = 18,
  parameter int unsigned EXIT_Y  = 13
) (
  input  logic                 vga_clk,
  input  logic                 clrn,
  maze_pixel_src_if.slave      vga,
  input  logic [3:0]           move_req,
  input  logic                 restart,
  output logic                 won,
  output logic [7:0]           moves
);

  localparam logic [4:0] START_PX = 5'(START_X);
  localparam logic [3:0] START_PY = 4'(START_Y);
  localparam logic [4:0] EXIT_PX  = 5'(EXIT_X);
  localparam logic [3:0] EXIT_PY  = 4'(EXIT_Y);

  state_e     state_q, state_d;
  logic [4:0] px_q, px_d;
  logic [3:0] py_q, py_d;
  logic [7:0] moves_q, moves_d;
  logic       won_q, won_d;
  logic       pend_v_q, pend_v_d;
  dir_e       pend_dir_q, pend_dir_d;
  logic       vs_q;

  logic       fs;
  logic [5:0] tgt_x;
  logic [4:0] tgt_y;
  logic       tgt_wall;
  logic       move_ok;

  logic [4:0] pix_tx;
  logic [3:0] pix_ty;
  logic       pix_wall;
  logic       in_mark;

  assign fs = vs_q && !vga.vs;

  // One extra bit on the target so stepping off tile 0 wraps to an out-of-range value
  always_comb begin
    tgt_x = {1'b0, px_q};
    tgt_y = {1'b0, py_q};
    case (pend_dir_q)
      DIR_UP:    tgt_y = {1'b0, py_q} - 5'd1;
      DIR_DOWN:  tgt_y = {1'b0, py_q} + 5'd1;
      DIR_LEFT:  tgt_x = {1'b0, px_q} - 6'd1;
      DIR_RIGHT: tgt_x = {1'b0, px_q} + 6'd1;
    endcase
  end

  maze_map_rom u_move_rom (
    .tx   (tgt_x[4:0]),
    .ty   (tgt_y[3:0]),
    .wall (tgt_wall)
  );

  assign move_ok = (tgt_x < 6'(MAP_W)) && (tgt_y < 5'(MAP_H)) && !tgt_wall;

  // Frame-start move is applied before the latch so a same-cycle request waits a frame
  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    moves_d    = moves_q;
    pend_v_d   = pend_v_q;
    pend_dir_d = pend_dir_q;
    if (restart) begin
      state_d  = PLAY;
      px_d     = START_PX;
      py_d     = START_PY;
      moves_d  = 8'd0;
      pend_v_d = 1'b0;
    end else if (state_q == PLAY) begin
      if (fs && pend_v_q) begin
        pend_v_d = 1'b0;
        if (move_ok) begin
          px_d = tgt_x[4:0];
          py_d = tgt_y[3:0];
          if (moves_q != 8'hFF) moves_d = moves_q + 8'd1;
          if (tgt_x[4:0] == EXIT_PX && tgt_y[3:0] == EXIT_PY) state_d = WIN;
        end
      end
      if (is_single(move_req)) begin
        pend_v_d   = 1'b1;
        pend_dir_d = req_to_dir(move_req);
      end
    end
    won_d = (state_d == WIN);
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= PLAY;
      px_q       <= START_PX;
      py_q       <= START_PY;
      moves_q    <= 8'd0;
      won_q      <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_dir_q <= DIR_UP;
      vs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      moves_q    <= moves_d;
      won_q      <= won_d;
      pend_v_q   <= pend_v_d;
      pend_dir_q <= pend_dir_d;
      vs_q       <= vga.vs;
    end
  end

  assign pix_tx  = vga.col_addr[9:5];
  assign pix_ty  = vga.row_addr[8:5];
  assign in_mark = (vga.col_addr[4:0] >= MARK_LO) && (vga.col_addr[4:0] <= MARK_HI) &&
                   (vga.row_addr[4:0] >= MARK_LO) && (vga.row_addr[4:0] <= MARK_HI);

  maze_map_rom u_pix_rom (
    .tx   (pix_tx),
    .ty   (pix_ty),
    .wall (pix_wall)
  );

  always_comb begin
    vga.d_out = FLOOR;
    if (vga.rdn) begin
      vga.d_out = BLANK;
    end else if (state_q == WIN) begin
      vga.d_out = EXIT;
    end else if (pix_wall) begin
      vga.d_out = WALL;
    end else if (pix_tx == px_q && pix_ty == py_q) begin
      vga.d_out = in_mark ? PLAYER : FLOOR;
    end else if (pix_tx == EXIT_PX && pix_ty == EXIT_PY) begin
      vga.d_out = EXIT;
    end
  end

  assign won   = won_q;
  assign moves = moves_q;

endmodule
